// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer: input synchronizers, button debouncers,
// run/pause/adjust state machine and the one-cycle strobes for the counter.
module stopwatch_ctrl #(
    parameter int unsigned ONE_HZ_DIV = 100000000,
    parameter int unsigned ADJ_DIV    = 50000000,
    parameter int unsigned BLINK_DIV  = 25000000,
    parameter int unsigned DB_CYCLES  = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pauseB,
    input  logic       rstB,
    input  logic       sel,
    input  logic       adj,
    output logic       secTick,
    output logic       adjMinTick,
    output logic       adjSecTick,
    output logic       clr,
    output logic       blink,
    output logic [1:0] state
);

    localparam int unsigned SEC_W   = $clog2(ONE_HZ_DIV + 1);
    localparam int unsigned ADJ_W   = $clog2(ADJ_DIV + 1);
    localparam int unsigned BLINK_W = $clog2(BLINK_DIV + 1);
    localparam int unsigned DB_W    = $clog2(DB_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RUN    = 2'b01,
        PAUSED = 2'b10,
        ADJUST = 2'b11
    } state_t;

    state_t cur, nxt;

    logic [3:0] sync1, sync2;
    logic [1:0] btn_s;
    logic [1:0] press;
    logic       sel_s, adj_s;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {adj, sel, rstB, pauseB};
            sync2 <= sync1;
        end
    end

    assign btn_s = sync2[1:0];
    assign sel_s = sync2[2];
    assign adj_s = sync2[3];

    // Bit 0 is the pause button, bit 1 the stopwatch-reset button.
    for (genvar g = 0; g < 2; g++) begin : g_db
        logic [DB_W-1:0] cnt;
        logic            lvl, lvl_d, pls;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                cnt   <= '0;
                lvl   <= 1'b0;
                lvl_d <= 1'b0;
                pls   <= 1'b0;
            end else begin
                lvl_d <= lvl;
                pls   <= lvl & ~lvl_d;
                if (btn_s[g] == lvl) begin
                    cnt <= '0;
                end else if (cnt == DB_W'(DB_CYCLES - 1)) begin
                    cnt <= '0;
                    lvl <= btn_s[g];
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end

        assign press[g] = pls;
    end

    logic [SEC_W-1:0]   sec_cnt;
    logic [ADJ_W-1:0]   adj_cnt;
    logic [BLINK_W-1:0] blink_cnt;
    logic               sec_due, adj_due, clr_n;

    assign sec_due = (cur == RUN)    && (sec_cnt == SEC_W'(ONE_HZ_DIV - 1));
    assign adj_due = (cur == ADJUST) && (adj_cnt == ADJ_W'(ADJ_DIV - 1));

    always_comb begin
        nxt   = cur;
        clr_n = 1'b0;
        if (adj_s && cur != ADJUST) begin
            nxt = ADJUST;
        end else if (cur == ADJUST && !adj_s) begin
            nxt = PAUSED;
        end else if (press[1]) begin
            clr_n = 1'b1;
            if (cur != ADJUST) nxt = IDLE;
        end else if (press[0]) begin
            case (cur)
                IDLE:    nxt = RUN;
                RUN:     nxt = PAUSED;
                PAUSED:  nxt = RUN;
                default: nxt = cur;
            endcase
        end
    end

    // Strobes are registered so each one lands exactly N cycles after entry;
    // a strobe is dropped if clr fires or the state leaves its mode on that edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur        <= IDLE;
            sec_cnt    <= '0;
            adj_cnt    <= '0;
            blink_cnt  <= '0;
            blink      <= 1'b0;
            clr        <= 1'b0;
            secTick    <= 1'b0;
            adjMinTick <= 1'b0;
            adjSecTick <= 1'b0;
        end else begin
            cur        <= nxt;
            clr        <= clr_n;
            secTick    <= sec_due && !clr_n && (nxt != ADJUST);
            adjMinTick <= adj_due && !clr_n && (nxt == ADJUST) && !sel_s;
            adjSecTick <= adj_due && !clr_n && (nxt == ADJUST) &&  sel_s;

            if (clr_n || cur == IDLE)
                sec_cnt <= '0;
            else if (cur == RUN)
                sec_cnt <= sec_due ? '0 : sec_cnt + 1'b1;

            if (cur != ADJUST)
                adj_cnt <= '0;
            else
                adj_cnt <= adj_due ? '0 : adj_cnt + 1'b1;

            if (cur != ADJUST || nxt != ADJUST) begin
                blink_cnt <= '0;
                blink     <= 1'b0;
            end else if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
                blink_cnt <= '0;
                blink     <= ~blink;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    assign state = cur;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with small dividers (10/5/4/3).
// Cycle indices count edges after the start of each scenario; inputs change 1 time unit after an edge.
module tb_stopwatch_ctrl;

    logic       clk = 1'b0;
    logic       rst, pauseB, rstB, sel, adj;
    logic       secTick, adjMinTick, adjSecTick, clr, blink;
    logic [1:0] state;

    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 clk = ~clk;

    stopwatch_ctrl #(
        .ONE_HZ_DIV(10),
        .ADJ_DIV   (5),
        .BLINK_DIV (4),
        .DB_CYCLES (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pauseB    (pauseB),
        .rstB      (rstB),
        .sel       (sel),
        .adj       (adj),
        .secTick   (secTick),
        .adjMinTick(adjMinTick),
        .adjSecTick(adjSecTick),
        .clr       (clr),
        .blink     (blink),
        .state     (state)
    );

    task automatic check(input string tag, input int unsigned got, input int unsigned want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", tag, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned want;
        rst = 1'b0; pauseB = 1'b0; rstB = 1'b0; sel = 1'b0; adj = 1'b0;

        // Reset held, then idle for 50 cycles.
        for (int i = 1; i <= 5; i++) begin
            step();
            check($sformatf("rst_state@%0d", i), state, 0);
            check($sformatf("rst_outs@%0d", i), {secTick, adjMinTick, adjSecTick, clr, blink}, 0);
        end
        rst = 1'b1;
        for (int i = 1; i <= 50; i++) begin
            step();
            check($sformatf("idle_state@%0d", i), state, 0);
            check($sformatf("idle_outs@%0d", i), {secTick, adjMinTick, adjSecTick, clr, blink}, 0);
        end

        // Start, pause after 25 RUN cycles, resume.
        pauseB = 1'b1;
        for (int c = 1; c <= 75; c++) begin
            step();
            want = (c < 7) ? 0 : (c < 32) ? 1 : (c < 57) ? 2 : 1;
            check($sformatf("run_state@%0d", c), state, want);
            check($sformatf("run_sectick@%0d", c), secTick, (c == 17 || c == 27 || c == 62 || c == 72));
            check($sformatf("run_clr@%0d", c), clr, 0);
            pauseB = (c < 10) || (c >= 25 && c < 35) || (c >= 50 && c < 60);
        end

        // Debounce: 2-cycle glitch ignored, 10-cycle press pauses.
        pauseB = 1'b1;
        for (int d = 1; d <= 30; d++) begin
            step();
            check($sformatf("db_state@%0d", d), state, (d < 19) ? 1 : 2);
            check($sformatf("db_sectick@%0d", d), secTick, (d == 7 || d == 17));
            pauseB = (d < 2) || (d >= 12 && d < 22);
        end

        // Reset priority: resume, then pause+reset together with a tick due.
        pauseB = 1'b1;
        for (int e = 1; e <= 45; e++) begin
            step();
            want = (e < 7) ? 2 : (e < 35) ? 1 : 0;
            check($sformatf("prio_state@%0d", e), state, want);
            check($sformatf("prio_sectick@%0d", e), secTick, (e == 15 || e == 25));
            check($sformatf("prio_clr@%0d", e), clr, (e == 35));
            pauseB = (e < 10) || (e >= 28 && e < 38);
            rstB   = (e >= 28 && e < 38);
        end

        // Adjust: minutes strobes, sel flip, ignored pause, exit to PAUSED.
        pauseB = 1'b1;
        for (int f = 1; f <= 55; f++) begin
            step();
            want = (f < 7) ? 0 : (f < 15) ? 1 : (f < 49) ? 3 : 2;
            check($sformatf("adj_state@%0d", f), state, want);
            check($sformatf("adj_sectick@%0d", f), secTick, 0);
            check($sformatf("adj_min@%0d", f), adjMinTick, (f == 20 || f == 25 || f == 30));
            check($sformatf("adj_sec@%0d", f), adjSecTick, (f == 35 || f == 40 || f == 45));
            want = (f >= 15 && f < 49) ? ((f - 15) / 4) % 2 : 0;
            check($sformatf("adj_blink@%0d", f), blink, want);
            pauseB = (f < 10) || (f >= 36 && f < 46);
            adj    = (f >= 12 && f < 46);
            sel    = (f >= 31);
        end

        // Reset mid-adjust, then a fresh RUN.
        adj = 1'b1;
        for (int g = 1; g <= 10; g++) begin
            step();
            check($sformatf("mid_state@%0d", g), state, (g < 3) ? 2 : 3);
            check($sformatf("mid_sec@%0d", g), adjSecTick, (g == 8));
            check($sformatf("mid_blink@%0d", g), blink, (g >= 7));
        end
        rst = 1'b0; adj = 1'b0; sel = 1'b0; pauseB = 1'b0;
        #1;
        check("async_rst_state", state, 0);
        check("async_rst_outs", {secTick, adjMinTick, adjSecTick, clr, blink}, 0);
        for (int i = 1; i <= 3; i++) begin
            step();
            check($sformatf("held_rst_state@%0d", i), state, 0);
            check($sformatf("held_rst_clr@%0d", i), clr, 0);
        end
        rst = 1'b1;
        pauseB = 1'b1;
        for (int h = 1; h <= 22; h++) begin
            step();
            check($sformatf("post_state@%0d", h), state, (h < 7) ? 0 : 1);
            check($sformatf("post_sectick@%0d", h), secTick, (h == 17));
            check($sformatf("post_clr@%0d", h), clr, 0);
            pauseB = (h < 10);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
